// File: rtl/neurosa_host_ctrl.sv
// neurosa_host_ctrl
// Host-side job sequencer for the neuron array. One job resets the array,
// sends the WR command, streams the configuration RAM onto the array's ins
// bus, drives the external field for the anneal, requests a readout, captures
// the spin-state words and drains them through a valid/ready stream.
module neurosa_host_ctrl #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NUM_NEURON      = 1024,
    parameter int NEURON_ID_WIDTH = 10,
    parameter int RST_CYCLES      = 2,
    localparam int RD_WORDS  = NUM_NEURON / 16,
    localparam int CFG_WORDS = 4 * NUM_NEURON,
    localparam int CFG_AW    = NEURON_ID_WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              run_cycles,
    input  logic [FP_DATA_WIDTH-1:0] mu_ext,
    output logic                     cfg_rd_en,
    output logic [CFG_AW-1:0]        cfg_addr,
    input  logic [FP_DATA_WIDTH-1:0] cfg_rdata,
    output logic                     chip_reset_l,
    output logic [FP_DATA_WIDTH-1:0] chip_ins,
    output logic                     chip_rd,
    input  logic [FP_DATA_WIDTH-1:0] chip_outs,
    output logic                     rdo_valid,
    output logic [15:0]              rdo_data,
    output logic                     rdo_last,
    input  logic                     rdo_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int RD_AW  = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;
    localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RST_W-1:0]         RST_LAST     = RST_W'(RST_CYCLES - 1);
    localparam logic [CFG_AW-1:0]        CFG_LAST     = CFG_AW'(CFG_WORDS - 1);
    localparam logic [CFG_AW-1:0]        CFG_PREF_END = CFG_AW'(CFG_WORDS - 2);
    localparam logic [RD_AW-1:0]         RD_LAST      = RD_AW'(RD_WORDS - 1);
    localparam logic [FP_DATA_WIDTH-1:0] WR_CMD       = FP_DATA_WIDTH'(1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHIP_RST = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;
    localparam logic [2:0] ST_READ_REQ = 3'd5;
    localparam logic [2:0] ST_CAPTURE  = 3'd6;
    localparam logic [2:0] ST_DRAIN    = 3'd7;

    logic [2:0]        state;
    logic [RST_W-1:0]  rst_cnt;
    logic [CFG_AW-1:0] load_cnt;
    logic [31:0]       run_cnt;
    logic [RD_AW-1:0]  word_cnt;
    logic [15:0]       buffer [RD_WORDS];

    // Prefetch config reads two cycles ahead of the word driven on chip_ins,
    // starting in the last reset cycle so the LOAD stream has no gaps.
    always_comb begin
        cfg_rd_en = 1'b0;
        cfg_addr  = '0;
        case (state)
            ST_CHIP_RST: begin
                if (rst_cnt == RST_LAST) begin
                    cfg_rd_en = 1'b1;
                end
            end
            ST_CMD: begin
                cfg_rd_en = 1'b1;
                cfg_addr  = CFG_AW'(1);
            end
            ST_LOAD: begin
                if (load_cnt < CFG_PREF_END) begin
                    cfg_rd_en = 1'b1;
                    cfg_addr  = load_cnt + CFG_AW'(2);
                end
            end
            default: begin
            end
        endcase
    end

    // Job sequencer: phase tracking plus the registered drive of the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rst_cnt      <= '0;
            load_cnt     <= '0;
            run_cnt      <= 32'd0;
            word_cnt     <= '0;
            chip_reset_l <= 1'b0;
            chip_ins     <= '0;
            chip_rd      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    chip_reset_l <= 1'b1;
                    chip_ins     <= '0;
                    chip_rd      <= 1'b0;
                    if (start) begin
                        state        <= ST_CHIP_RST;
                        busy         <= 1'b1;
                        chip_reset_l <= 1'b0;
                        rst_cnt      <= '0;
                        run_cnt      <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;
                    end
                end
                ST_CHIP_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state        <= ST_CMD;
                        chip_reset_l <= 1'b1;
                        chip_ins     <= WR_CMD;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                ST_CMD: begin
                    state    <= ST_LOAD;
                    load_cnt <= '0;
                    chip_ins <= cfg_rdata;
                end
                ST_LOAD: begin
                    if (load_cnt == CFG_LAST) begin
                        state    <= ST_RUN;
                        chip_ins <= mu_ext;
                    end else begin
                        load_cnt <= load_cnt + CFG_AW'(1);
                        chip_ins <= cfg_rdata;
                    end
                end
                ST_RUN: begin
                    chip_ins <= mu_ext;
                    if (run_cnt == 32'd1) begin
                        state   <= ST_READ_REQ;
                        chip_rd <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt - 32'd1;
                    end
                end
                ST_READ_REQ: begin
                    state    <= ST_CAPTURE;
                    chip_rd  <= 1'b0;
                    chip_ins <= '0;
                    word_cnt <= '0;
                end
                ST_CAPTURE: begin
                    if (word_cnt == RD_LAST) begin
                        state    <= ST_DRAIN;
                        word_cnt <= '0;
                    end else begin
                        word_cnt <= word_cnt + RD_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (rdo_ready) begin
                        if (word_cnt == RD_LAST) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + RD_AW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Readout capture buffer; contents only matter once CAPTURE has refilled it.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE) begin
            buffer[word_cnt] <= chip_outs[15:0];
        end
    end

    // Drain side of the stream is derived from the phase and word pointer,
    // so data and last stay put for as long as the consumer stalls.
    always_comb begin
        rdo_valid = (state == ST_DRAIN);
        rdo_last  = rdo_valid && (word_cnt == RD_LAST);
        rdo_data  = rdo_valid ? buffer[word_cnt] : 16'h0000;
    end

endmodule
